// File: rtl/spi_sclk_engine_pkg.sv
// Shared definitions for the SPI SCLK engine: FSM states, divider floor, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_sclk_engine_pkg;

    // Shortest legal SCLK period in system clocks
    localparam int unsigned SPI_MIN_DIV = 2;

    localparam int DEF_DIV_W = 8;
    localparam int DEF_LEN_W = 6;
    localparam int DEF_DLY_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_TRAIL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/spi_sclk_engine_if.sv
// Bundle between the SPI register block (master) and the SCLK engine (slave).
// Latency: n/a (wires only).
// Backpressure: none; i_start is a request sampled only while the engine is idle.
// Signals: i_enable/i_start/i_divider/i_len/i_cpol/i_cpha/i_lead/i_trail in;
//          o_sclk/o_cs_n/o_busy/o_load/o_sample/o_shift/o_last/o_bit_idx/o_done out.
interface spi_sclk_engine_if
    import spi_sclk_engine_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int DLY_W = DEF_DLY_W
)();
    logic             i_enable;
    logic             i_start;
    logic [DIV_W-1:0] i_divider;
    logic [LEN_W-1:0] i_len;
    logic             i_cpol;
    logic             i_cpha;
    logic [DLY_W-1:0] i_lead;
    logic [DLY_W-1:0] i_trail;

    logic             o_sclk;
    logic             o_cs_n;
    logic             o_busy;
    logic             o_load;
    logic             o_sample;
    logic             o_shift;
    logic             o_last;
    logic [LEN_W-1:0] o_bit_idx;
    logic             o_done;

    modport slave (
        input  i_enable, i_start, i_divider, i_len, i_cpol, i_cpha, i_lead, i_trail,
        output o_sclk, o_cs_n, o_busy, o_load, o_sample, o_shift, o_last, o_bit_idx, o_done
    );

    modport master (
        output i_enable, i_start, i_divider, i_len, i_cpol, i_cpha, i_lead, i_trail,
        input  o_sclk, o_cs_n, o_busy, o_load, o_sample, o_shift, o_last, o_bit_idx, o_done
    );
endinterface

// File: rtl/spi_sclk_engine_phase_cnt.sv
// Loadable up/down counter with wrap and terminal-count flag.
// Latency: count updates one cycle after i_load/i_en; o_tc is combinational on the count.
// Backpressure: none.
// Ports: i_clk, i_rst, i_load/i_load_val (load wins), i_en (step), i_wrap (up: terminal
//        value, wraps to 0; down: reload value after 0), o_cnt, o_tc.
module spi_phase_cnt #(
    parameter int W  = 8,
    parameter bit UP = 1'b1
)(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_wrap,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);
    logic [W-1:0] r_cnt;
    logic [W-1:0] w_nxt;
    logic         w_tc;

    always_comb begin
        w_tc  = UP ? (r_cnt == i_wrap) : (r_cnt == '0);
        w_nxt = r_cnt;
        if (i_load) begin
            w_nxt = i_load_val;
        end else if (i_en) begin
            if (w_tc) w_nxt = UP ? '0 : i_wrap;
            else      w_nxt = UP ? (r_cnt + W'(1)) : (r_cnt - W'(1));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_cnt <= '0;
        else       r_cnt <= w_nxt;
    end

    assign o_cnt = r_cnt;
    assign o_tc  = w_tc;
endmodule

// File: rtl/spi_sclk_engine.sv
// SPI SCLK engine: CS framing, SCLK generation for all CPOL/CPHA modes, shift-register strobes.
// Latency: first busy cycle one clock after i_start is accepted; o_sclk/o_cs_n are registered.
// Backpressure: i_start is ignored while busy (no queuing); i_enable low aborts next cycle.
// Ports: i_clk, i_rst (sync, active high), bus (slave side of spi_sclk_engine_if).
module spi_sclk_engine
    import spi_sclk_engine_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int DLY_W = DEF_DLY_W
)(
    input  logic             i_clk,
    input  logic             i_rst,
    spi_sclk_engine_if.slave bus
);
    state_t           r_state, w_nxt_state;

    // Configuration captured at acceptance; later input changes do not disturb a transfer
    logic [DIV_W-1:0] r_div;
    logic [LEN_W-1:0] r_len;
    logic             r_cpol;
    logic             r_cpha;
    logic [DLY_W-1:0] r_trail;

    logic             r_sclk;
    logic             r_cs_n;
    logic             r_load;
    logic [LEN_W-1:0] r_bit_idx;

    logic             w_accept;
    logic             w_dly_load;
    logic [DLY_W-1:0] w_dly_load_val;
    logic             w_dly_tc;
    logic [DLY_W-1:0] w_dly_cnt_unused;
    logic [DIV_W-1:0] w_per_cnt;
    logic             w_per_tc;
    logic [DIV_W-1:0] w_per_nxt;
    logic [DIV_W-1:0] w_half;
    logic             w_bit_last;
    logic             w_lead_edge;
    logic             w_trail_edge;
    logic             w_sclk_nxt;
    logic             w_busy_nxt;

    assign w_half     = r_div >> 1;
    assign w_bit_last = (r_bit_idx == (r_len - LEN_W'(1)));

    // Counts L-1..0 in LEAD and T-1..0 in TRAIL
    spi_phase_cnt #(.W(DLY_W), .UP(1'b0)) u_dly_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_dly_load),
        .i_load_val (w_dly_load_val),
        .i_en       ((r_state == ST_LEAD) || (r_state == ST_TRAIL)),
        .i_wrap     ({DLY_W{1'b0}}),
        .o_cnt      (w_dly_cnt_unused),
        .o_tc       (w_dly_tc)
    );

    // Position within the current bit, 0..D-1; held at 0 outside RUN
    spi_phase_cnt #(.W(DIV_W), .UP(1'b1)) u_per_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (r_state != ST_RUN),
        .i_load_val ({DIV_W{1'b0}}),
        .i_en       (r_state == ST_RUN),
        .i_wrap     (r_div - DIV_W'(1)),
        .o_cnt      (w_per_cnt),
        .o_tc       (w_per_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_nxt_state;
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_accept       = 1'b0;
        w_dly_load     = 1'b0;
        w_dly_load_val = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_enable && bus.i_start) begin
                    w_accept       = 1'b1;
                    w_nxt_state    = ST_LEAD;
                    w_dly_load     = 1'b1;
                    w_dly_load_val = (bus.i_lead == '0) ? '0 : (bus.i_lead - DLY_W'(1));
                end
            end
            ST_LEAD: begin
                if (!bus.i_enable)  w_nxt_state = ST_IDLE;
                else if (w_dly_tc)  w_nxt_state = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.i_enable) begin
                    w_nxt_state = ST_IDLE;
                end else if (w_per_tc && w_bit_last) begin
                    if (r_trail == '0) begin
                        w_nxt_state = ST_DONE;
                    end else begin
                        w_nxt_state    = ST_TRAIL;
                        w_dly_load     = 1'b1;
                        w_dly_load_val = r_trail - DLY_W'(1);
                    end
                end
            end
            ST_TRAIL: begin
                if (!bus.i_enable)  w_nxt_state = ST_IDLE;
                else if (w_dly_tc)  w_nxt_state = ST_DONE;
            end
            ST_DONE:  w_nxt_state = ST_IDLE;
            default:  w_nxt_state = ST_IDLE;
        endcase
    end

    // Registered SCLK is computed from next-cycle position so the pin comes straight off a flop
    assign w_per_nxt  = ((r_state == ST_RUN) && !w_per_tc) ? (w_per_cnt + DIV_W'(1)) : '0;
    assign w_busy_nxt = (w_nxt_state == ST_LEAD) || (w_nxt_state == ST_RUN) ||
                        (w_nxt_state == ST_TRAIL);

    always_comb begin
        if (w_nxt_state == ST_RUN)   w_sclk_nxt = r_cpol ^ (w_per_nxt < w_half);
        else if (r_state == ST_IDLE) w_sclk_nxt = bus.i_cpol;
        else                         w_sclk_nxt = r_cpol;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div     <= '0;
            r_len     <= '0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_trail   <= '0;
            r_sclk    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_load    <= 1'b0;
            r_bit_idx <= '0;
        end else begin
            if (w_accept) begin
                r_div   <= (bus.i_divider < DIV_W'(SPI_MIN_DIV)) ? DIV_W'(SPI_MIN_DIV) : bus.i_divider;
                r_len   <= (bus.i_len == '0) ? LEN_W'(1) : bus.i_len;
                r_cpol  <= bus.i_cpol;
                r_cpha  <= bus.i_cpha;
                r_trail <= bus.i_trail;
            end
            r_sclk <= w_sclk_nxt;
            r_cs_n <= !w_busy_nxt;
            r_load <= w_accept;
            // Index advances on each period wrap; parked at 0 outside RUN
            if (w_nxt_state != ST_RUN)
                r_bit_idx <= '0;
            else if ((r_state == ST_RUN) && w_per_tc)
                r_bit_idx <= r_bit_idx + LEN_W'(1);
        end
    end

    assign w_lead_edge  = (r_state == ST_RUN) && (w_per_cnt == '0);
    assign w_trail_edge = (r_state == ST_RUN) && (w_per_cnt == w_half);

    assign bus.o_sclk    = r_sclk;
    assign bus.o_cs_n    = r_cs_n;
    assign bus.o_busy    = (r_state == ST_LEAD) || (r_state == ST_RUN) || (r_state == ST_TRAIL);
    assign bus.o_load    = r_load;
    assign bus.o_sample  = r_cpha ? w_trail_edge : w_lead_edge;
    // In mode cpha=0 the final trailing edge has no next bit to shift out
    assign bus.o_shift   = r_cpha ? w_lead_edge : (w_trail_edge && !w_bit_last);
    assign bus.o_last    = (r_state == ST_RUN) && w_bit_last;
    assign bus.o_bit_idx = r_bit_idx;
    assign bus.o_done    = (r_state == ST_DONE);
endmodule

// File: tb/tb_spi_sclk_engine.sv
// Testbench for spi_sclk_engine: per-cycle scoreboard of all outputs against a cycle model.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_sclk_engine;
    import spi_sclk_engine_pkg::*;

    typedef struct packed {
        logic       sclk;
        logic       cs_n;
        logic       busy;
        logic       load;
        logic       sample;
        logic       shift;
        logic       last;
        logic       done;
        logic [5:0] bit_idx;
    } obs_t;

    typedef struct packed {
        obs_t v;
        obs_t m;
    } sb_t;

    localparam logic [13:0] M_ALL = 14'h3FFF;
    localparam logic [13:0] M_NOB = 14'h3FC0;

    localparam int K_NORMAL = 0;
    localparam int K_ABORT  = 1;
    localparam int K_RESET  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_sclk_engine_if bus();

    spi_sclk_engine dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    sb_t exp_q[$];
    int  n_err    = 0;
    int  n_checks = 0;

    function automatic obs_t observe();
        obs_t o;
        o.sclk    = bus.o_sclk;
        o.cs_n    = bus.o_cs_n;
        o.busy    = bus.o_busy;
        o.load    = bus.o_load;
        o.sample  = bus.o_sample;
        o.shift   = bus.o_shift;
        o.last    = bus.o_last;
        o.done    = bus.o_done;
        o.bit_idx = bus.o_bit_idx;
        return o;
    endfunction

    function automatic sb_t mk(input logic sclk, input logic cs_n, input logic busy,
                               input logic load, input logic smp, input logic shf,
                               input logic last, input logic done, input int bidx,
                               input logic [13:0] mask);
        sb_t s;
        s.v.sclk = sclk;  s.v.cs_n = cs_n;  s.v.busy = busy;  s.v.load = load;
        s.v.sample = smp; s.v.shift = shf;  s.v.last = last;  s.v.done = done;
        s.v.bit_idx = 6'(bidx);
        s.m = mask;
        return s;
    endfunction

    // Cycle model: one entry per clock from the first busy cycle onward.
    // cut>0 truncates after that cycle and appends the abort or reset aftermath.
    task automatic push_expected(input int div, input int len, input logic cpol, input logic cpha,
                                 input int lead, input int trail, input int cut, input int kind);
        sb_t q[$];
        int d, n, l, h, k, p;
        logic le, te;
        d = (div < 2) ? 2 : div;
        n = (len < 1) ? 1 : len;
        l = (lead < 1) ? 1 : lead;
        h = d / 2;
        for (int j = 0; j < l; j++)
            q.push_back(mk(cpol, 1'b0, 1'b1, (j == 0), 1'b0, 1'b0, 1'b0, 1'b0, 0, M_NOB));
        for (int c = 0; c < n * d; c++) begin
            k  = c / d;
            p  = c % d;
            le = (p == 0);
            te = (p == h);
            q.push_back(mk((p < h) ? ~cpol : cpol, 1'b0, 1'b1, 1'b0,
                           cpha ? te : le,
                           cpha ? le : (te && (k != n - 1)),
                           (k == n - 1), 1'b0, k, M_ALL));
        end
        for (int j = 0; j < trail; j++)
            q.push_back(mk(cpol, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, M_NOB));
        q.push_back(mk(cpol, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, M_NOB));
        q.push_back(mk(cpol, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, M_NOB));
        if (cut > 0) begin
            while (q.size() > cut) void'(q.pop_back());
            if (kind == K_RESET)
                q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, M_ALL));
            for (int j = 0; j < 2; j++)
                q.push_back(mk(cpol, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, M_NOB));
        end
        foreach (q[i]) exp_q.push_back(q[i]);
    endtask

    // Presents config and raises i_start; acceptance happens at the following edge
    task automatic start_xfer(input int div, input int len, input logic cpol, input logic cpha,
                              input int lead, input int trail);
        @(posedge clk); #1;
        bus.i_divider = 8'(div);
        bus.i_len     = 6'(len);
        bus.i_cpol    = cpol;
        bus.i_cpha    = cpha;
        bus.i_lead    = 4'(lead);
        bus.i_trail   = 4'(trail);
        bus.i_start   = 1'b1;
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        bus.i_enable = 1'b1; bus.i_start = 1'b0; bus.i_divider = '0; bus.i_len = '0;
        bus.i_cpol = 1'b0; bus.i_cpha = 1'b0; bus.i_lead = '0; bus.i_trail = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        o = observe();
        n_checks++;
        if (o !== 14'h1000) begin
            n_err++;
            $display("FAIL reset_values got=%h want=%h", o, 14'h1000);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.i_cpol = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.o_sclk !== 1'b0) begin
            n_err++;
            $display("FAIL idle_cpol_delay got=%b want=0", bus.o_sclk);
        end
        @(negedge clk);
        n_checks++;
        if (bus.o_sclk !== 1'b1) begin
            n_err++;
            $display("FAIL idle_cpol_follow got=%b want=1", bus.o_sclk);
        end
    endtask

    task automatic test_mode0();
        obs_t o; sb_t e; int j, smp, shf, done_at;
        j = 0; smp = 0; shf = 0; done_at = -1;
        push_expected(4, 2, 1'b0, 1'b0, 1, 1, 0, K_NORMAL);
        start_xfer(4, 2, 1'b0, 1'b0, 1, 1);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; j++;
            if (j == 1) bus.i_start = 1'b0;
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            smp += int'(o.sample); shf += int'(o.shift);
            if (o.done) done_at = j;
            n_checks++;
            if ((o & e.m) !== (e.v & e.m)) begin
                n_err++;
                $display("FAIL mode0 cyc=%0d got=%h want=%h mask=%h", j, o, e.v, e.m);
            end
        end
        n_checks++;
        if (smp != 2 || shf != 1 || done_at != 11) begin
            n_err++;
            $display("FAIL mode0_counts samples=%0d shifts=%0d done_at=%0d want 2/1/11", smp, shf, done_at);
        end
    endtask

    task automatic test_mode3();
        obs_t o; sb_t e; int j, smp, shf, run;
        j = 0; smp = 0; shf = 0; run = 0;
        push_expected(5, 3, 1'b1, 1'b1, 2, 0, 0, K_NORMAL);
        start_xfer(5, 3, 1'b1, 1'b1, 2, 0);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; j++;
            if (j == 1) bus.i_start = 1'b0;
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            smp += int'(o.sample); shf += int'(o.shift);
            if (o.busy && (j > 2)) run++;
            n_checks++;
            if ((o & e.m) !== (e.v & e.m)) begin
                n_err++;
                $display("FAIL mode3 cyc=%0d got=%h want=%h mask=%h", j, o, e.v, e.m);
            end
        end
        n_checks++;
        if (smp != 3 || shf != 3 || run != 15) begin
            n_err++;
            $display("FAIL mode3_counts samples=%0d shifts=%0d run=%0d want 3/3/15", smp, shf, run);
        end
    endtask

    task automatic test_min_clamp();
        obs_t o; sb_t e; int j, smp;
        for (int t = 0; t < 2; t++) begin
            j = 0; smp = 0;
            push_expected(t, 0, logic'(t), logic'(t), 0, 0, 0, K_NORMAL);
            start_xfer(t, 0, logic'(t), logic'(t), 0, 0);
            while (exp_q.size() > 0) begin
                @(posedge clk); #1; j++;
                if (j == 1) bus.i_start = 1'b0;
                @(negedge clk);
                e = exp_q.pop_front();
                o = observe();
                smp += int'(o.sample);
                n_checks++;
                if ((o & e.m) !== (e.v & e.m)) begin
                    n_err++;
                    $display("FAIL clamp%0d cyc=%0d got=%h want=%h mask=%h", t, j, o, e.v, e.m);
                end
            end
            n_checks++;
            if (smp != 1) begin
                n_err++;
                $display("FAIL clamp%0d_samples got=%0d want=1", t, smp);
            end
        end
    endtask

    task automatic test_abort();
        obs_t o; sb_t e; int j, dones;
        j = 0; dones = 0;
        // Enable drops during RUN cycle 5 (second cycle of bit 1)
        push_expected(4, 3, 1'b0, 1'b0, 1, 1, 7, K_ABORT);
        push_expected(4, 3, 1'b0, 1'b0, 1, 1, 0, K_NORMAL);
        start_xfer(4, 3, 1'b0, 1'b0, 1, 1);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; j++;
            if (j == 1)  bus.i_start  = 1'b0;
            if (j == 7)  bus.i_enable = 1'b0;
            if (j == 9)  begin bus.i_enable = 1'b1; bus.i_start = 1'b1; end
            if (j == 10) bus.i_start  = 1'b0;
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            if (j <= 9) dones += int'(o.done);
            n_checks++;
            if ((o & e.m) !== (e.v & e.m)) begin
                n_err++;
                $display("FAIL abort cyc=%0d got=%h want=%h mask=%h", j, o, e.v, e.m);
            end
        end
        n_checks++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL abort_no_done got=%0d want=0", dones);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o; sb_t e; int j, loads, dones;
        j = 0; loads = 0; dones = 0;
        push_expected(4, 2, 1'b0, 1'b1, 2, 2, 0, K_NORMAL);
        push_expected(3, 1, 1'b0, 1'b1, 2, 2, 0, K_NORMAL);
        start_xfer(4, 2, 1'b0, 1'b1, 2, 2);
        // i_start stays high through the first transfer; config changes mid-flight
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; j++;
            if (j == 4)  begin bus.i_divider = 8'd3; bus.i_len = 6'd1; end
            if (j == 15) bus.i_start = 1'b0;
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            loads += int'(o.load); dones += int'(o.done);
            n_checks++;
            if ((o & e.m) !== (e.v & e.m)) begin
                n_err++;
                $display("FAIL b2b cyc=%0d got=%h want=%h mask=%h", j, o, e.v, e.m);
            end
        end
        n_checks++;
        if (loads != 2 || dones != 2) begin
            n_err++;
            $display("FAIL b2b_counts loads=%0d dones=%0d want 2/2", loads, dones);
        end
    endtask

    task automatic test_reset_trail();
        obs_t o; sb_t e; int j;
        j = 0;
        // TRAIL spans cycles 4..7; reset is sampled at the end of cycle 5
        push_expected(2, 1, 1'b1, 1'b0, 1, 4, 5, K_RESET);
        start_xfer(2, 1, 1'b1, 1'b0, 1, 4);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1; j++;
            if (j == 1) bus.i_start = 1'b0;
            if (j == 5) rst = 1'b1;
            if (j == 6) rst = 1'b0;
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            n_checks++;
            if ((o & e.m) !== (e.v & e.m)) begin
                n_err++;
                $display("FAIL rst_trail cyc=%0d got=%h want=%h mask=%h", j, o, e.v, e.m);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_min_clamp();
        test_abort();
        test_back_to_back();
        test_reset_trail();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
